// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//   Exhaustively exercises one N_IN-input, single-output combinational gate.
//   Every input row 0..R-1 is driven in ascending order and held for SETTLE
//   cycles. The gate output is sampled on the last edge of that window. The
//   captured truth table is assembled as a Wolfram-style rule word and then
//   compared with an expected rule that is latched when the sweep is accepted.
//
//   Rule bit order: row k (input vector {in1..inN} == k) lands in rule bit
//   R-1-k, so rule bit R-1 holds the output for row 0.
//
// Parameters
//   N_IN    number of gate inputs (rule width R = 2**N_IN)
//   SETTLE  cycles each row is held before sampling (>= 1)
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_start       request a sweep (accepted only in IDLE, and only without abort)
//   i_abort       cancel a running sweep
//   i_rule_exp    expected rule word, latched on start accept
//   i_dut_out     output of the gate under evaluation
//   o_drv_in      gate inputs; o_drv_in[N_IN-1] is in1 (MSB of the row index)
//   o_busy        high while a sweep is running (RUN and REPORT)
//   o_done        one-cycle pulse when the results are valid
//   o_meas_rule   measured rule word
//   o_mismatch    o_meas_rule XOR latched expected rule
//   o_pass        mismatch == 0
//   o_fail_valid  at least one row mismatched
//   o_fail_idx    lowest mismatching row index (0 if none)
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 4,
  localparam int R      = 1 << N_IN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [R-1:0]    i_rule_exp,
  input  logic            i_dut_out,
  output logic [N_IN-1:0] o_drv_in,
  output logic            o_busy,
  output logic            o_done,
  output logic [R-1:0]    o_meas_rule,
  output logic [R-1:0]    o_mismatch,
  output logic            o_pass,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_fail_idx
);

  // A single-cycle settle window still needs a 1-bit counter.
  localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]   ROW_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_IN-1:0]   r_row;
  logic [CNT_W-1:0]  r_cnt;
  logic [R-1:0]      r_exp;
  logic [R-1:0]      r_meas;
  logic [R-1:0]      r_mismatch;
  logic              r_pass;
  logic              r_fail_valid;
  logic [N_IN-1:0]   r_fail_idx;
  logic [N_IN-1:0]   r_drv;
  logic              r_busy;
  logic              r_done;

  // Result evaluation, consumed only on the edge that leaves REPORT.
  logic [R-1:0]      w_mismatch;
  logic [N_IN-1:0]   w_fail_idx;
  logic              w_sample;
  logic              w_last_row;

  assign w_mismatch = r_meas ^ r_exp;
  assign w_sample   = (r_cnt == CNT_LAST);
  assign w_last_row = (r_row == ROW_LAST);

  // Lowest mismatching row. Row k lives at rule bit R-1-k, so scanning rows
  // from high to low and overwriting leaves the smallest k in place.
  always_comb begin
    w_fail_idx = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (w_mismatch[R-1-k]) w_fail_idx = N_IN'(k);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_meas       <= '0;
      r_mismatch   <= '0;
      r_pass       <= 1'b0;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_drv        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the REPORT exit raises it.
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_drv  <= '0;
          r_busy <= 1'b0;
          // start together with abort is treated as no request.
          if (i_start && !i_abort) begin
            r_exp        <= i_rule_exp;
            r_row        <= '0;
            r_cnt        <= '0;
            r_meas       <= '0;
            r_mismatch   <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_drv        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_RUN;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            // Partial capture stays visible in meas_rule; no verdict.
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_drv        <= '0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_cnt        <= '0;
            r_row        <= '0;
          end else if (w_sample) begin
            // Last cycle of this row's settle window: capture the gate.
            r_meas[ROW_LAST - r_row] <= i_dut_out;
            r_cnt                    <= '0;
            if (w_last_row) begin
              r_state <= S_REPORT;
            end else begin
              r_row <= r_row + 1'b1;
              r_drv <= r_row + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_REPORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_drv   <= '0;
          r_row   <= '0;
          if (i_abort) begin
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
          end else begin
            r_mismatch   <= w_mismatch;
            r_pass       <= (w_mismatch == '0);
            r_fail_valid <= |w_mismatch;
            r_fail_idx   <= w_fail_idx;
            r_done       <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_drv   <= '0;
        end
      endcase
    end
  end

  assign o_drv_in     = r_drv;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_meas_rule  = r_meas;
  assign o_mismatch   = r_mismatch;
  assign o_pass       = r_pass;
  assign o_fail_valid = r_fail_valid;
  assign o_fail_idx   = r_fail_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//   Drives truth_table_sweeper against a behavioural gate whose rule and fault
//   mask are chosen by the bench. A cycle-timeline model (time since accept,
//   row = t / SETTLE) predicts every output and is compared each cycle on the
//   falling edge. Directed scenarios add literal expectations for the model.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;
  localparam int N_IN   = 3;
  localparam int SETTLE = 4;
  localparam int R      = 1 << N_IN;
  localparam int SWEEP  = R * SETTLE;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [R-1:0]    rule_exp = '0;
  logic            dut_out = 1'b0;
  logic [N_IN-1:0] drv_in;
  logic            busy, done, pass, fail_valid;
  logic [R-1:0]    meas_rule, mismatch;
  logic [N_IN-1:0] fail_idx;

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_rule_exp(rule_exp), .i_dut_out(dut_out),
    .o_drv_in(drv_in), .o_busy(busy), .o_done(done),
    .o_meas_rule(meas_rule), .o_mismatch(mismatch), .o_pass(pass),
    .o_fail_valid(fail_valid), .o_fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gate under evaluation: a rule word plus a fault mask in rule-bit order.
  logic [R-1:0] gate_rule = 8'hC1;
  logic [R-1:0] fault     = '0;

  function automatic logic gate_f(input int k);
    logic [R-1:0] g;
    g = gate_rule ^ fault;
    return g[R-1-k];
  endfunction

  // ---------------- behavioural model ----------------
  bit              m_run = 0;
  int              m_t = 0;        // edges since the accept edge
  logic [R-1:0]    m_exp = '0, m_meas = '0, m_mm = '0;
  logic            m_pass = 0, m_fv = 0, m_done = 0;
  logic [N_IN-1:0] m_fidx = '0;
  bit              chk_en = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_exp = '0; m_meas = '0; m_mm = '0;
      m_pass = 0; m_fv = 0; m_done = 0; m_fidx = '0; chk_en = 1;
    end else if (m_run) begin
      m_done = 0;
      if (abort) begin
        m_run = 0; m_pass = 0; m_fv = 0;
      end else begin
        m_t++;
        if (m_t <= SWEEP && m_t % SETTLE == 0)
          m_meas[R-1-(m_t/SETTLE-1)] = gate_f(m_t/SETTLE - 1);
        if (m_t == SWEEP + 1) begin
          bit found;
          m_mm   = m_meas ^ m_exp;
          m_pass = (m_mm == '0);
          m_fv   = (m_mm != '0);
          m_fidx = '0;
          found  = 0;
          for (int k = 0; k < R; k++)
            if (!found && m_mm[R-1-k]) begin m_fidx = N_IN'(k); found = 1; end
          m_done = 1;
          m_run  = 0;
        end
      end
    end else begin
      m_done = 0;
      if (start && !abort) begin
        m_run = 1; m_t = 0; m_exp = rule_exp; m_meas = '0; m_mm = '0;
        m_pass = 0; m_fv = 0; m_fidx = '0;
      end
    end
  end

  // Gate response: correct only in the cycle before a sample edge, noise
  // everywhere else, so any off-edge sampling shows up in meas_rule.
  always @(negedge clk) begin
    if (m_run && m_t < SWEEP && m_t % SETTLE == SETTLE - 1)
      dut_out = gate_f(int'(drv_in));
    else
      dut_out = 1'($urandom_range(0, 1));
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      if (!(m_run && m_t >= SWEEP))
        chk("drv_in", 32'(drv_in), m_run ? 32'(m_t / SETTLE) : 32'd0);
      chk("meas_rule", 32'(meas_rule), 32'(m_meas));
      chk("mismatch", 32'(mismatch), 32'(m_mm));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail_valid", 32'(fail_valid), 32'(m_fv));
      chk("fail_idx", 32'(fail_idx), 32'(m_fidx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns in the cycle right after the accept edge.
  task automatic accept(input logic [R-1:0] e);
    rule_exp = e; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Counts cycles since accept until done is seen (bounded).
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < 200) begin tick(1); c++; end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(1); n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_meas", 32'(meas_rule), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Clean gate 0xC1.
    gate_rule = 8'hC1; fault = '0;
    accept(8'hC1);
    wait_done(0, c);
    chk("s1_done_lat", 32'(c), 32'd33);
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_meas", 32'(meas_rule), 32'hC1);
    chk("s1_mm", 32'(mismatch), 32'h00);
    chk("s1_pass", 32'(pass), 32'd1);
    chk("s1_fv", 32'(fail_valid), 32'd0);
    tick(2);

    // Row 3 stuck at 1.
    fault = 8'h10;
    accept(8'hC1);
    wait_done(0, c);
    chk("s2_meas", 32'(meas_rule), 32'hD1);
    chk("s2_mm", 32'(mismatch), 32'h10);
    chk("s2_pass", 32'(pass), 32'd0);
    chk("s2_fv", 32'(fail_valid), 32'd1);
    chk("s2_idx", 32'(fail_idx), 32'd3);
    tick(2);

    // Rows 3 and 6 faulted.
    fault = 8'h12;
    accept(8'hC1);
    wait_done(0, c);
    chk("s2b_mm", 32'(mismatch), 32'h12);
    chk("s2b_idx", 32'(fail_idx), 32'd3);
    tick(2);

    // start pulse at E10 with rule_exp changed mid-run: ignored.
    fault = '0;
    accept(8'hC1);
    tick(9);
    start = 1'b1; rule_exp = 8'h00;
    tick(1);
    start = 1'b0;
    wait_done(10, c);
    chk("s3_done_lat", 32'(c), 32'd33);
    chk("s3_pass", 32'(pass), 32'd1);
    chk("s3_mm", 32'(mismatch), 32'h00);
    tick(2);

    // abort at E15.
    accept(8'hC1);
    tick(14);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("s4_busy", 32'(busy), 32'd0);
    chk("s4_drv", 32'(drv_in), 32'd0);
    chk("s4_pass", 32'(pass), 32'd0);
    tick(40);
    accept(8'hC1);
    wait_done(0, c);
    chk("s4_rerun_pass", 32'(pass), 32'd1);
    tick(2);

    // Reset at E20 with start also high.
    accept(8'hC1);
    tick(19);
    rst_n = 1'b0; start = 1'b1;
    tick(1);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_drv", 32'(drv_in), 32'd0);
    chk("s5_meas", 32'(meas_rule), 32'd0);
    start = 1'b0; rst_n = 1'b1;
    tick(2);
    accept(8'hC1);
    wait_done(0, c);
    chk("s5_rerun_pass", 32'(pass), 32'd1);
    tick(2);

    // start held through the done cycle: back-to-back sweeps.
    rule_exp = 8'hC1; start = 1'b1;
    tick(1);
    wait_done(0, c);
    chk("s6_done_lat", 32'(c), 32'd33);
    tick(1);
    start = 1'b0;
    chk("s6_busy", 32'(busy), 32'd1);
    chk("s6_drv", 32'(drv_in), 32'd0);
    wait_done(0, c);
    chk("s6_done_lat2", 32'(c), 32'd33);
    tick(2);

    // Randomized sweeps with noise on start/abort/rule_exp.
    for (int it = 0; it < 30; it++) begin
      int mode, ab_at;
      gate_rule = R'($urandom);
      fault     = ($urandom_range(0, 2) == 0) ? '0 : R'(1 << $urandom_range(0, R-1));
      mode      = $urandom_range(0, 3);
      ab_at     = $urandom_range(1, SWEEP + 1);
      accept(($urandom_range(0, 1) == 0) ? gate_rule : R'($urandom));
      for (int cyc = 1; cyc <= SWEEP + 2; cyc++) begin
        abort = (mode == 0 && cyc == ab_at);
        start = (mode == 1 && cyc < SWEEP) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (mode == 2) rule_exp = R'($urandom);
        tick(1);
      end
      abort = 1'b0; start = 1'b0;
      wait_idle();
      tick($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively exercises one N-input, single-output combinational logic gate (Wolfram-coded truth-table function).
- Drives every input combination in ascending order, holds each for a settle window, then samples the gate output.
- Assembles the measured truth table as a rule word and compares it with an expected rule.
- Sits between the test/configuration controller and the gate under evaluation.

Parameters:
- N_IN, 3, number of gate inputs; the rule width is R = 2^N_IN.
- SETTLE, 4, cycles each input row is held before sampling; must be >= 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a sweep; accepted only in IDLE.
- abort  input  1  cancel a running sweep.
- rule_exp  input  R  expected rule word; latched on start accept.
- dut_out  input  1  output of the gate under evaluation.
- drv_in  output  N_IN  gate inputs; drv_in[N_IN-1] is in1 (MSB of the row index).
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when results are valid.
- meas_rule  output  R  measured rule word.
- mismatch  output  R  meas_rule XOR latched rule_exp.
- pass  output  1  high when mismatch == 0.
- fail_valid  output  1  high when at least one row mismatched.
- fail_idx  output  N_IN  lowest mismatching row index.

Behaviour:
- Reset: rst_n low at an edge puts the state in IDLE and clears drv_in, busy, done, meas_rule, mismatch, pass, fail_valid, fail_idx and the internal counters. Reset overrides start and abort. Reset in mid-sweep takes effect at that edge.
- Rule bit order: row k is the input vector {in1..inN} = k. Rule bit (R-1-k) holds the output for row k, so rule bit R-1 corresponds to row 0.
- States: IDLE, RUN, REPORT.
- IDLE:
  - busy=0 and drv_in=0.
  - start=1 and abort=0 at edge E0: latch rule_exp into exp_q, set row=0 and cnt=0, clear meas_rule, mismatch, pass, fail_valid and fail_idx, set busy=1, go to RUN.
  - start and abort both high in IDLE: start is ignored.
- RUN:
  - drv_in = row (registered).
  - At each edge with cnt < SETTLE-1: cnt increments.
  - At an edge with cnt == SETTLE-1: meas_rule[R-1-row] <= dut_out. If row == R-1, go to REPORT; otherwise row increments and cnt returns to 0.
  - Row k is therefore driven for exactly SETTLE cycles and sampled at edge E(k*SETTLE + SETTLE). The last sample is at edge E(R*SETTLE).
- REPORT (one cycle):
  - At the edge leaving REPORT: compute mismatch = meas_rule ^ exp_q, pass = (mismatch==0), fail_valid = |mismatch, and fail_idx = smallest k with mismatch[R-1-k] set (0 if none).
  - Same edge: done=1 for exactly one cycle, busy=0, drv_in=0, go to IDLE.
  - done is first high in the cycle after edge E(R*SETTLE+1), and busy is low in that same cycle.
- Results hold until the next accepted start or reset.
- start while busy (RUN or REPORT) is ignored. rule_exp changes after the accept edge have no effect.
- A start asserted during the done cycle is accepted, because the state is already IDLE.
- abort=1 in RUN or REPORT: go to IDLE at that edge with busy=0 and drv_in=0. done is not pulsed, pass=0, fail_valid=0, and meas_rule keeps the partially captured bits.
- dut_out is sampled exactly once per row. Values outside the sample edges are don't-care.

Test Plan:
- Gate model 0xC1 (000→1, 001→1, 111→1, others 0), N_IN=3, SETTLE=4, rule_exp=0xC1, start at E0.
  - Required: drv_in steps 0,1,…,7 with each value held 4 cycles; samples at E4, E8, …, E32.
  - Required: done in the cycle after E33 with busy=0, meas_rule=0xC1, mismatch=0x00, pass=1, fail_valid=0.
- Same setup, but the gate is faulted so row 3 (011) outputs 1.
  - Required: meas_rule=0xD1, mismatch=0x10, pass=0, fail_valid=1, fail_idx=3.
  - Add a second fault on row 6 → mismatch=0x12, fail_idx still 3.
- start pulses at E10, with rule_exp changed to 0x00 during the run.
  - Required: no restart; completion timing as in scenario 1; results compared against 0xC1.
- abort at E15.
  - Required: after E15 busy=0 and drv_in=0; no done pulse; pass=0.
  - A subsequent start gives full, correct results.
- rst_n low at E20 mid-sweep, with start also high at E20.
  - Required: all outputs 0 after E20 and the state is IDLE.
  - Releasing reset and then issuing start runs a normal sweep.
- start held high through the done cycle.
  - Required: the second sweep is accepted in the done cycle, busy returns to 1 the next cycle, and drv_in restarts at 0.
